cdb_scheduler: RTL and testbench

//  Issue-time scheduler for the common data bus (CDB). Decides each cycle which

---
 rtl/cdb_scheduler_pkg.sv | 17 +
 rtl/cdb_slot_ring.sv | 70 +++++++
 rtl/cdb_scheduler.sv | 162 ++++++++++++++++
 tb/tb_cdb_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_scheduler_pkg.sv
// Shared types for the CDB scheduler: producer select codes and helpers.
package cdb_scheduler_pkg;

    typedef enum logic [1:0] {
        CDB_SEL_INT  = 2'd0,
        CDB_SEL_LS   = 2'd1,
        CDB_SEL_MULT = 2'd2,
        CDB_SEL_DIV  = 2'd3
    } cdb_sel_e;

    localparam int N_UNITS = 4;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cdb_slot_ring.sv
// Reservation shift register: slot i books the CDB for cycle now+1+i.
// The head register is the live CDB drive.
module cdb_slot_ring
    import cdb_scheduler_pkg::*;
#(
    parameter int DEPTH    = 7,
    parameter int W_TAG    = 6,
    parameter int LAT_INT  = 1,
    parameter int LAT_LS   = 2,
    parameter int LAT_MULT = 4,
    parameter int IW       = idx_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  cdb_sel_e         wr_sel,
    input  logic [W_TAG-1:0] wr_tag,
    output logic [3:0]       reserved,
    output logic             cdb_valid,
    output logic [W_TAG-1:0] cdb_tag,
    output logic [1:0]       cdb_sel
);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_w;
    cdb_sel_e         s   [DEPTH];
    cdb_sel_e         s_w [DEPTH];
    logic [W_TAG-1:0] t   [DEPTH];
    logic [W_TAG-1:0] t_w [DEPTH];

    assign reserved = {v[DEPTH-1], v[LAT_MULT-1], v[LAT_LS-1], v[LAT_INT-1]};

    always_comb begin
        v_w = v;
        s_w = s;
        t_w = t;
        if (wr_en) begin
            v_w[wr_idx] = 1'b1;
            s_w[wr_idx] = wr_sel;
            t_w[wr_idx] = wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v         <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_sel   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                s[i] <= CDB_SEL_INT;
                t[i] <= '0;
            end
        end else begin
            cdb_valid <= v_w[0];
            cdb_tag   <= v_w[0] ? t_w[0] : '0;
            cdb_sel   <= v_w[0] ? s_w[0] : '0;
            for (int i = 0; i < DEPTH - 1; i++) begin
                v[i] <= v_w[i+1];
                s[i] <= s_w[i+1];
                t[i] <= t_w[i+1];
            end
            v[DEPTH-1] <= 1'b0;
            s[DEPTH-1] <= CDB_SEL_INT;
            t[DEPTH-1] <= '0;
        end
    end

endmodule

// File: rtl/cdb_scheduler.sv
// CDB issue scheduler: eligibility, arbitration and divider occupancy.
// Define CDB_SCHED_RR_EN for round-robin; default is fixed div>mult>ls>int.
module cdb_scheduler
    import cdb_scheduler_pkg::*;
#(
    parameter int W_TAG    = 6,
    parameter int INT_LAT  = 1,
    parameter int LS_LAT   = 2,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             int_ready,
    input  logic [W_TAG-1:0] int_rdtag,
    input  logic             ls_ready,
    input  logic             ls_opcode,
    input  logic [W_TAG-1:0] ls_rttag,
    input  logic             mult_ready,
    input  logic [W_TAG-1:0] mult_rdtag,
    input  logic             div_ready,
    input  logic [W_TAG-1:0] div_rdtag,
    output logic             int_done,
    output logic             ls_done,
    output logic             mult_done,
    output logic             div_done,
    output logic             cdb_valid,
    output logic [W_TAG-1:0] cdb_tag,
    output logic [1:0]       cdb_sel,
    output logic             div_busy
);

    localparam int IW = idx_w(DIV_LAT);
    localparam int CW = $clog2(DIV_LAT + 1);

    logic             active;
    logic             ok;
    logic [3:0]       reserved;
    logic [3:0]       elig;
    logic [3:0]       grant;
    logic [CW-1:0]    div_cnt;
    logic             wr_en;
    logic [IW-1:0]    wr_idx;
    cdb_sel_e         wr_sel;
    logic [W_TAG-1:0] wr_tag;

    // Grants are held off in reset and for one cycle after it.
    always_ff @(posedge clk) begin
        active <= reset;
    end

    assign ok = active & reset;

    assign elig[CDB_SEL_INT]  = ok & int_ready & ~reserved[0];
    assign elig[CDB_SEL_LS]   = ok & ls_ready & (ls_opcode | ~reserved[1]);
    assign elig[CDB_SEL_MULT] = ok & mult_ready & ~reserved[2];
    assign elig[CDB_SEL_DIV]  = ok & div_ready & ~div_busy & ~reserved[3];

`ifdef CDB_SCHED_RR_EN
    cdb_sel_e   rr_ptr;
    logic [1:0] rr_idx;
    logic [1:0] rr_win;
    logic       rr_hit;

    always_comb begin
        rr_hit = 1'b0;
        rr_win = rr_ptr;
        rr_idx = rr_ptr;
        grant  = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            rr_idx = rr_ptr + 2'(k);
            if (!rr_hit && elig[rr_idx]) begin
                rr_hit = 1'b1;
                rr_win = rr_idx;
            end
        end
        if (rr_hit) grant[rr_win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) rr_ptr <= CDB_SEL_INT;
        else if (rr_hit) rr_ptr <= cdb_sel_e'(rr_win + 2'd1);
    end
`else
    always_comb begin
        grant = '0;
        priority case (1'b1)
            elig[CDB_SEL_DIV]:  grant[CDB_SEL_DIV]  = 1'b1;
            elig[CDB_SEL_MULT]: grant[CDB_SEL_MULT] = 1'b1;
            elig[CDB_SEL_LS]:   grant[CDB_SEL_LS]   = 1'b1;
            elig[CDB_SEL_INT]:  grant[CDB_SEL_INT]  = 1'b1;
            default: ;
        endcase
    end
`endif

    assign int_done  = grant[CDB_SEL_INT];
    assign ls_done   = grant[CDB_SEL_LS];
    assign mult_done = grant[CDB_SEL_MULT];
    assign div_done  = grant[CDB_SEL_DIV];

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = '0;
        wr_sel = CDB_SEL_INT;
        wr_tag = '0;
        unique case (1'b1)
            grant[CDB_SEL_INT]: begin
                wr_en  = 1'b1;
                wr_idx = IW'(INT_LAT - 1);
                wr_tag = int_rdtag;
            end
            grant[CDB_SEL_LS]: begin
                wr_en  = ~ls_opcode;
                wr_idx = IW'(LS_LAT - 1);
                wr_sel = CDB_SEL_LS;
                wr_tag = ls_rttag;
            end
            grant[CDB_SEL_MULT]: begin
                wr_en  = 1'b1;
                wr_idx = IW'(MULT_LAT - 1);
                wr_sel = CDB_SEL_MULT;
                wr_tag = mult_rdtag;
            end
            grant[CDB_SEL_DIV]: begin
                wr_en  = 1'b1;
                wr_idx = IW'(DIV_LAT - 1);
                wr_sel = CDB_SEL_DIV;
                wr_tag = div_rdtag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) div_cnt <= '0;
        else if (grant[CDB_SEL_DIV]) div_cnt <= CW'(DIV_LAT - 1);
        else if (div_cnt != '0) div_cnt <= div_cnt - 1'b1;
    end

    assign div_busy = (div_cnt != '0);

    cdb_slot_ring #(
        .DEPTH    (DIV_LAT),
        .W_TAG    (W_TAG),
        .LAT_INT  (INT_LAT),
        .LAT_LS   (LS_LAT),
        .LAT_MULT (MULT_LAT)
    ) u_ring (
        .clk       (clk),
        .rst_n     (reset),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_sel    (wr_sel),
        .wr_tag    (wr_tag),
        .reserved  (reserved),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_sel   (cdb_sel)
    );

endmodule

// File: tb/tb_cdb_scheduler.sv
// Bench for cdb_scheduler: directed vector table, then random traffic vs model.
module tb_cdb_scheduler;

    localparam int LAT_I = 1;
    localparam int LAT_L = 2;
    localparam int LAT_M = 4;
    localparam int LAT_D = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       int_ready, ls_ready, ls_opcode, mult_ready, div_ready;
    logic [5:0] int_rdtag, ls_rttag, mult_rdtag, div_rdtag;
    logic       int_done, ls_done, mult_done, div_done;
    logic       cdb_valid, div_busy;
    logic [5:0] cdb_tag;
    logic [1:0] cdb_sel;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    cdb_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .int_ready  (int_ready),
        .int_rdtag  (int_rdtag),
        .ls_ready   (ls_ready),
        .ls_opcode  (ls_opcode),
        .ls_rttag   (ls_rttag),
        .mult_ready (mult_ready),
        .mult_rdtag (mult_rdtag),
        .div_ready  (div_ready),
        .div_rdtag  (div_rdtag),
        .int_done   (int_done),
        .ls_done    (ls_done),
        .mult_done  (mult_done),
        .div_done   (div_done),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_sel    (cdb_sel),
        .div_busy   (div_busy)
    );

    typedef struct {
        logic       ir;
        logic [5:0] itag;
        logic       lr;
        logic       lop;
        logic [5:0] ltag;
        logic       mr;
        logic [5:0] mtag;
        logic       dr;
        logic [5:0] dtag;
        logic [3:0] edone;
        logic       ecv;
        logic [5:0] etag;
        logic [1:0] esel;
        logic       ebusy;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(input int ir, itag, lr, lop, ltag, mr, mtag,
                                input int dr, dtag, edone, ecv, etag, esel, ebusy);
        vec_t v;
        v.ir = ir[0];     v.itag = itag[5:0];
        v.lr = lr[0];     v.lop = lop[0];     v.ltag = ltag[5:0];
        v.mr = mr[0];     v.mtag = mtag[5:0];
        v.dr = dr[0];     v.dtag = dtag[5:0];
        v.edone = edone[3:0];
        v.ecv = ecv[0];   v.etag = etag[5:0]; v.esel = esel[1:0];
        v.ebusy = ebusy[0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic [3:0] dones();
        return {div_done, mult_done, ls_done, int_done};
    endfunction

    task automatic drive(input logic rst, input logic ir, input logic [5:0] it,
                         input logic lr, input logic lop, input logic [5:0] lt,
                         input logic mr, input logic [5:0] mt,
                         input logic dr, input logic [5:0] dt);
        reset = rst;
        int_ready = ir;  int_rdtag = it;
        ls_ready = lr;   ls_opcode = lop;  ls_rttag = lt;
        mult_ready = mr; mult_rdtag = mt;
        div_ready = dr;  div_rdtag = dt;
    endtask

    // reference model state: expected CDB contents keyed by absolute cycle
    int  exp_tag [int];
    int  exp_sel [int];
    int  last_div;
    int  ptr;
    bit  inact;
    int  lat [4];

    initial begin
        lat = '{LAT_I, LAT_L, LAT_M, LAT_D};

        tbl[0]  = mk(1,5,  0,0,0,  0,0,  0,0,  4'b0000, 0,0,0, 0);
        tbl[1]  = mk(1,5,  0,0,0,  0,0,  0,0,  4'b0001, 0,0,0, 0);
        tbl[2]  = mk(0,0,  0,0,0,  0,0,  0,0,  4'b0000, 1,5,0, 0);
        tbl[3]  = mk(0,0,  0,0,0,  1,9,  0,0,  4'b0100, 0,0,0, 0);
        tbl[4]  = mk(0,0,  0,0,0,  0,0,  0,0,  4'b0000, 0,0,0, 0);
        tbl[5]  = mk(0,0,  1,1,33, 0,0,  0,0,  4'b0010, 0,0,0, 0);
        tbl[6]  = mk(1,3,  0,0,0,  0,0,  0,0,  4'b0000, 0,0,0, 0);
        tbl[7]  = mk(1,3,  0,0,0,  0,0,  0,0,  4'b0001, 1,9,2, 0);
        tbl[8]  = mk(0,0,  0,0,0,  0,0,  0,0,  4'b0000, 1,3,0, 0);
        tbl[9]  = mk(0,0,  0,0,0,  0,0,  1,12, 4'b1000, 0,0,0, 0);
        for (int i = 10; i <= 15; i++)
            tbl[i] = mk(0,0, 0,0,0, 0,0, 1,12, 4'b0000, 0,0,0, 1);
        tbl[16] = mk(0,0,  0,0,0,  0,0,  1,12, 4'b1000, 1,12,3, 0);
        tbl[17] = mk(0,0,  1,1,40, 0,0,  0,0,  4'b0010, 0,0,0, 1);
        tbl[18] = mk(0,0,  1,0,20, 0,0,  0,0,  4'b0010, 0,0,0, 1);
        tbl[19] = mk(1,22, 1,0,21, 0,0,  0,0,  4'b0010, 0,0,0, 1);
        tbl[20] = mk(1,22, 0,0,0,  0,0,  0,0,  4'b0000, 1,20,1, 1);
        tbl[21] = mk(1,22, 0,0,0,  0,0,  0,0,  4'b0001, 1,21,1, 1);

        // reset with every queue ready
        drive(1'b0, 1,1, 1,0,2, 1,3, 1,4);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_done", 32'(dones()), 0);
        chk("rst_cv", 32'(cdb_valid), 0);
        chk("rst_tag", 32'(cdb_tag), 0);
        chk("rst_sel", 32'(cdb_sel), 0);
        chk("rst_busy", 32'(div_busy), 0);

        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            #1;
            drive(1'b1, tbl[i].ir, tbl[i].itag, tbl[i].lr, tbl[i].lop, tbl[i].ltag,
                  tbl[i].mr, tbl[i].mtag, tbl[i].dr, tbl[i].dtag);
            @(negedge clk);
            chk($sformatf("tbl%0d_done", i), 32'(dones()), 32'(tbl[i].edone));
            chk($sformatf("tbl%0d_cv", i), 32'(cdb_valid), 32'(tbl[i].ecv));
            if (tbl[i].ecv) begin
                chk($sformatf("tbl%0d_tag", i), 32'(cdb_tag), 32'(tbl[i].etag));
                chk($sformatf("tbl%0d_sel", i), 32'(cdb_sel), 32'(tbl[i].esel));
            end
            chk($sformatf("tbl%0d_busy", i), 32'(div_busy), 32'(tbl[i].ebusy));
        end

        // reset while the second divide is still in flight
        @(posedge clk);
        #1;
        drive(1'b0, 1,1, 1,0,2, 1,3, 1,4);
        @(negedge clk);
        chk("mid_rst_done", 32'(dones()), 0);
        chk("mid_rst_cv", 32'(cdb_valid), 1);
        chk("mid_rst_tag", 32'(cdb_tag), 22);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("in_rst_done", 32'(dones()), 0);
            chk("in_rst_cv", 32'(cdb_valid), 0);
            chk("in_rst_busy", 32'(div_busy), 0);
        end

        exp_tag.delete();
        exp_sel.delete();
        last_div = -100;
        ptr      = 0;
        inact    = 1'b1;

        for (int c = 0; c < 1500; c++) begin
            logic       rv;
            logic [3:0] rdy;
            logic       lop;
            logic [5:0] tg [4];
            logic [3:0] el;
            logic [3:0] edone;
            int         u;
            int         d;
            bit         ecv;
            bit         ebusy;

            rv  = !(c > 30 && $urandom_range(0, 79) == 0);
            rdy = (c < 12) ? 4'hF : 4'($urandom);
            lop = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 4; k++) tg[k] = 6'($urandom);

            @(posedge clk);
            #1;
            drive(rv, rdy[0], tg[0], rdy[1], lop, tg[1], rdy[2], tg[2], rdy[3], tg[3]);

            d     = c - last_div;
            ebusy = (d >= 1) && (d <= LAT_D - 1);
            ecv   = exp_tag.exists(c);
            u     = -1;
            el    = '0;
            if (rv && !inact) begin
                for (int k = 0; k < 4; k++)
                    el[k] = rdy[k] && ((k == 1 && lop) || !exp_tag.exists(c + lat[k]));
                if (ebusy) el[3] = 1'b0;
`ifdef CDB_SCHED_RR_EN
                for (int k = 0; k < 4; k++)
                    if (u < 0 && el[(ptr + k) % 4]) u = (ptr + k) % 4;
`else
                for (int k = 3; k >= 0; k--)
                    if (u < 0 && el[k]) u = k;
`endif
            end
            edone = '0;
            if (u >= 0) edone[u] = 1'b1;

            @(negedge clk);
            chk("rnd_done", 32'(dones()), 32'(edone));
            chk("rnd_cv", 32'(cdb_valid), 32'(ecv));
            if (ecv) begin
                chk("rnd_tag", 32'(cdb_tag), 32'(exp_tag[c]));
                chk("rnd_sel", 32'(cdb_sel), 32'(exp_sel[c]));
            end
            chk("rnd_busy", 32'(div_busy), 32'(ebusy));

            if (u >= 0) begin
                if (!(u == 1 && lop)) begin
                    exp_tag[c + lat[u]] = int'(tg[u]);
                    exp_sel[c + lat[u]] = u;
                end
                if (u == 3) last_div = c;
                ptr = (u + 1) % 4;
            end
            if (exp_tag.exists(c)) begin
                exp_tag.delete(c);
                exp_sel.delete(c);
            end
            if (!rv) begin
                exp_tag.delete();
                exp_sel.delete();
                last_div = -100;
                ptr      = 0;
                inact    = 1'b1;
            end else begin
                inact = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
